btn_debounce: RTL
=================

# btn_debounce

Push-button conditioner that sits directly upstream of the LED blinker and the other board-level consumers of user buttons. It synchronises a raw, bouncing, asynchronous button input into the `CLK` domain and filters it with a counter-based debounce state machine. It then produces a clean level plus single-cycle press and release strobes, and optionally a one-shot long-press strobe. All outputs are registered.

## Interface
- `DB_CYCLES`, default 16: number of consecutive agreeing synchronised samples, beyond the first, required to accept a transition. Legal range is 1 to 2^`CNT_WIDTH`-1.
- `LONG_CYCLES`, default 256: cycles in HELD before the long-press strobe fires. Legal range is 1 to 2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, default 20: width of the shared debounce/long-press counter.

Ports:
- `CLK`  input  1  sole clock; all state is updated on the rising edge.
- `RST_X`  input  1  asynchronous, active-low reset.
- `BTN_IN`  input  1  raw button, active-high, asynchronous to `CLK`.
- `BTN_LEVEL`  output  1  debounced button state (1 = pressed).
- `BTN_PRESS`  output  1  one-cycle strobe on an accepted press.
- `BTN_RELEASE`  output  1  one-cycle strobe on an accepted release.
- `BTN_LONG`  output  1  one-cycle strobe when the hold exceeds `LONG_CYCLES` (see Configuration).

## Operation
- **Synchroniser.** Two flops, `s1` then `s2`; `s2` is the only value the FSM samples. Both reset to 0.
- **FSM states.** IDLE, PRESS_WAIT, HELD, REL_WAIT. Reset state is IDLE with `cnt` = 0.
- **IDLE.**
  - `s2`=1: go to PRESS_WAIT, `cnt`<=1.
  - Otherwise stay.
- **PRESS_WAIT.**
  - `s2`=0: go to IDLE, `cnt`<=0. This is a bounce; no strobe is issued.
  - `s2`=1 and `cnt`==`DB_CYCLES`: go to HELD, `cnt`<=0, `BTN_LEVEL`<=1, `BTN_PRESS`<=1.
  - `s2`=1 otherwise: `cnt`<=`cnt`+1.
- **HELD.**
  - `s2`=0: go to REL_WAIT, `cnt`<=1.
  - `s2`=1: long-press counting applies (see Configuration).
- **REL_WAIT.**
  - `s2`=1: go back to HELD. `cnt` is restored to 0 and long-press tracking is not re-armed.
  - `s2`=0 and `cnt`==`DB_CYCLES`: go to IDLE, `cnt`<=0, `BTN_LEVEL`<=0, `BTN_RELEASE`<=1.
  - `s2`=0 otherwise: `cnt`<=`cnt`+1.
- **Strobes.** `BTN_PRESS`, `BTN_RELEASE` and `BTN_LONG` are cleared every cycle unless set by the rules above. At most one of them is high in any cycle.
- **Reset.** Assertion of `RST_X` forces all outputs to 0 immediately (asynchronous), with state IDLE and `cnt` 0. This holds mid-operation. If the button is still held when reset is released, it is debounced as a new press and produces a fresh `BTN_PRESS`.
- **Counter width.** `cnt` never exceeds max(`DB_CYCLES`, `LONG_CYCLES`), so no wrap-around is possible within the legal parameter range.

## Timing
- Reset values: `BTN_LEVEL`=0, `BTN_PRESS`=0, `BTN_RELEASE`=0, `BTN_LONG`=0.
- Press latency:
  - `BTN_IN` is first sampled high by `s1` at edge k and stays high.
  - `BTN_PRESS` and `BTN_LEVEL` rise after edge k+2+`DB_CYCLES`.
  - `BTN_PRESS` falls after the next edge.
- Release latency is symmetric: `BTN_RELEASE` rises after edge k+2+`DB_CYCLES`, where k is the first low sample.
- Rejection: any high pulse on `BTN_IN` lasting ≤ `DB_CYCLES` cycles produces no output activity.
- Back-to-back: a new press can be accepted no earlier than the cycle after `BTN_RELEASE`.

## Configuration
- Macro `BTN_DEBOUNCE_LONGPRESS_EN`.
- **Defined:**
  - In HELD with `s2`=1, `cnt` increments while `cnt` < `LONG_CYCLES`.
  - On the transition to `cnt`==`LONG_CYCLES`, `BTN_LONG` pulses for one cycle. `cnt` then saturates, so the strobe fires exactly once per accepted press.
  - A REL_WAIT→HELD bounce does not re-fire it.
- **Undefined:**
  - `BTN_LONG` is tied to 0.
  - `cnt` stays 0 throughout HELD.
  - No long-press logic is synthesised.
  - The port remains present.

## Test plan
- **Clean press.** `DB_CYCLES`=4; drive `BTN_IN`=1 sampled at edge 10 → `BTN_PRESS`=1 and `BTN_LEVEL`=1 after edge 16; `BTN_PRESS`=0 after edge 17.
- **Bounce rejection.** `DB_CYCLES`=4; pulses of 1, 3 and 4 cycles high separated by 2 low cycles → all outputs stay 0. A subsequent steady high → exactly one `BTN_PRESS`.
- **Release with chatter.** While HELD, toggle `BTN_IN` 0/1 every 2 cycles for 20 cycles, then hold low → `BTN_LEVEL` stays 1 through the chatter. Exactly one `BTN_RELEASE`, 6 edges after the final fall is sampled.
- **Long press, macro defined.** `LONG_CYCLES`=8; hold 40 cycles → exactly one `BTN_LONG`, 8 cycles after `BTN_PRESS`. With the macro undefined, `BTN_LONG` stays 0.
- **Reset mid-hold.** Assert `RST_X`=0 asynchronously while in HELD with `BTN_IN`=1 → `BTN_LEVEL` drops to 0 before the next edge. After release of `RST_X`, a new `BTN_PRESS` appears `DB_CYCLES`+3 edges later.
- **Strobe exclusivity.** Randomised `BTN_IN`, 10k cycles → never more than one strobe high in a cycle. `BTN_PRESS` and `BTN_RELEASE` strictly alternate, with `BTN_PRESS` first.

Source files
------------

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronised, counter-debounced push button with press/release strobes
// Optional long-press strobe enabled by defining BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce #(
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 256,
  parameter int CNT_WIDTH   = 20
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE,
  output logic BTN_LONG
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  localparam int unsigned CNT_TOP_I = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam logic [CNT_WIDTH-1:0] DB_C    = CNT_WIDTH'(DB_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(CNT_TOP_I);

  logic                 s1;
  logic                 s2;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_WIDTH-1:0] LONG_C = CNT_WIDTH'(LONG_CYCLES);
  logic long_q;
  logic long_done;
  assign BTN_LONG = long_q;
`else
  assign BTN_LONG = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN_IN;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      BTN_LEVEL   <= 1'b0;
      BTN_PRESS   <= 1'b0;
      BTN_RELEASE <= 1'b0;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
      long_q      <= 1'b0;
      long_done   <= 1'b0;
`endif
    end else begin
      BTN_PRESS   <= 1'b0;
      BTN_RELEASE <= 1'b0;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
      long_q      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DB_C) begin
            state     <= ST_HELD;
            cnt       <= '0;
            BTN_LEVEL <= 1'b1;
            BTN_PRESS <= 1'b1;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
            long_done <= 1'b0;
`endif
          end else if (cnt != CNT_TOP) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s2) begin
            state <= ST_REL_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
          // long_done survives release bounces so the strobe fires once per press
          else if (!long_done) begin
            cnt <= cnt + 1'b1;
            if (cnt == LONG_C - 1'b1) begin
              long_q    <= 1'b1;
              long_done <= 1'b1;
            end
          end
`endif
        end
        ST_REL_WAIT: begin
          if (s2) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == DB_C) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            BTN_LEVEL   <= 1'b0;
            BTN_RELEASE <= 1'b1;
          end else if (cnt != CNT_TOP) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
